// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the moving-average block: running-sum width,
// fill-counter width and the round-half-up offset.
package moving_average_pkg;

    // Wide enough to hold the exact sum of 2**log2_depth samples.
    function automatic int sum_width(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    function automatic int fill_width(input int log2_depth);
        return log2_depth + 1;
    endfunction

    function automatic int round_offset(input int log2_depth);
        return (log2_depth == 0) ? 0 : (1 << (log2_depth - 1));
    endfunction

endpackage

// File: rtl/moving_average_ring.sv
// Ring buffer of the last DEPTH samples. Exposes the entry about to be
// overwritten so the caller can retire it from its running sum in the same cycle.
module moving_average_ring
    import moving_average_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] oldest
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         wr_ptr_next;
    logic signed [DATA_W-1:0] slot_bus [DEPTH];

    // Entries are plain registers: every slot must read zero after reset/clear,
    // and the oldest entry is needed combinationally.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic signed [DATA_W-1:0] slot_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (clear) begin
                    slot_reg <= '0;
                end else if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= wr_data;
                end
            end

            assign slot_bus[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (wr_ptr_reg == PTR_W'(DEPTH - 1)) begin
            wr_ptr_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    assign oldest = slot_bus[wr_ptr_reg];

endmodule

// File: rtl/moving_average_n.sv
// Windowed moving average over the last 2**LOG2_DEPTH signed samples, 1-cycle latency.
// Define MOVING_AVERAGE_N_ROUND_EN for round-half-up instead of floor.
module moving_average_n
    import moving_average_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic [LOG2_DEPTH:0]      fill,
    output logic                     primed
);
    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = sum_width(DATA_W, LOG2_DEPTH);
    localparam int FILL_W = fill_width(LOG2_DEPTH);

    logic                     accept;
    logic signed [DATA_W-1:0] oldest;
    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  sum_adj;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [DATA_W-1:0] avg;
    logic [FILL_W-1:0]        fill_reg;
    logic                     out_valid_reg;
    logic signed [DATA_W-1:0] out_data_reg;

    // Clear has priority: a sample arriving with clear is dropped.
    assign accept = in_valid && !clear;

    moving_average_ring #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (system1000),
        .rst     (system1000_rst),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (in_data),
        .oldest  (oldest)
    );

    // The window sum always fits SUM_W, so modular intermediate wrap is harmless;
    // the rounding offset also stays below the positive limit.
    always_comb begin
        sum_next = sum_reg + SUM_W'(in_data) - SUM_W'(oldest);
`ifdef MOVING_AVERAGE_N_ROUND_EN
        sum_adj  = sum_next + SUM_W'(round_offset(LOG2_DEPTH));
`else
        sum_adj  = sum_next;
`endif
        shifted  = sum_adj >>> LOG2_DEPTH;
        avg      = shifted[DATA_W-1:0];
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            sum_reg       <= '0;
            fill_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= accept;
            if (clear) begin
                sum_reg  <= '0;
                fill_reg <= '0;
            end else if (accept) begin
                sum_reg      <= sum_next;
                out_data_reg <= avg;
                if (fill_reg != FILL_W'(DEPTH)) begin
                    fill_reg <= fill_reg + FILL_W'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign fill      = fill_reg;
    assign primed    = (fill_reg == FILL_W'(DEPTH));

endmodule

// File: tb/tb_moving_average_n.sv
// Directed bench for moving_average_n (DATA_W=8, LOG2_DEPTH=2); a window model
// is checked every cycle, plus hand-computed literal expectations.
module tb_moving_average_n;
    localparam int DEPTH = 4;

    logic              system1000;
    logic              system1000_rst;
    logic              clear;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic [2:0]        fill;
    logic              primed;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 0;

    // Model state: window contents, fill and expected outputs.
    int win [DEPTH];
    int wpos;
    int m_fill;
    int exp_valid;
    int exp_data;

    moving_average_n #(
        .DATA_W     (8),
        .LOG2_DEPTH (2)
    ) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .fill           (fill),
        .primed         (primed)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic int window_average();
        int s;
        int q;
        s = 0;
        for (int i = 0; i < DEPTH; i++) s += win[i];
`ifdef MOVING_AVERAGE_N_ROUND_EN
        s += DEPTH / 2;
`endif
        // floor(s / DEPTH) for either sign
        q = s / DEPTH;
        if ((s % DEPTH != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) win[i] = 0;
        wpos = 0;
        m_fill = 0;
        exp_valid = 0;
        exp_data = 0;
    endtask

    task automatic model_apply(input bit v, input int d, input bit c);
        if (c) begin
            for (int i = 0; i < DEPTH; i++) win[i] = 0;
            wpos = 0;
            m_fill = 0;
            exp_valid = 0;
        end else if (v) begin
            win[wpos] = d;
            wpos = (wpos + 1) % DEPTH;
            if (m_fill < DEPTH) m_fill++;
            exp_data = window_average();
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cycle(input bit v, input int d, input bit c);
        in_valid = v;
        in_data  = 8'(d);
        clear    = c;
        @(posedge system1000);
        model_apply(v, d, c);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear = 1'b0;
        in_data = '0;
        system1000_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge system1000);
        #1;
        system1000_rst = 1'b0;
    endtask

    always @(negedge system1000) begin
        if (check_en) begin
            check("cyc_valid", int'(out_valid), exp_valid);
            check("cyc_data", int'(out_data), exp_data);
            check("cyc_fill", int'(fill), m_fill);
            check("cyc_primed", int'(primed), (m_fill == DEPTH) ? 1 : 0);
            if (out_valid) $display("txn t=%0t out_data=%0d fill=%0d primed=%0b", $time, out_data, fill, primed);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        system1000_rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        model_reset();
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_primed", int'(primed), 0);
        do_reset();
        check_en = 1;

        // Warm-up with 4s: averages include zeros for unfilled slots.
        cycle(1, 4, 0); check("warm_o1", int'(out_data), 1); check("warm_f1", int'(fill), 1);
        cycle(1, 4, 0); check("warm_o2", int'(out_data), 2);
        cycle(1, 4, 0); check("warm_o3", int'(out_data), 3); check("warm_p3", int'(primed), 0);
        cycle(1, 4, 0); check("warm_o4", int'(out_data), 4); check("warm_p4", int'(primed), 1);
        cycle(1, 4, 0); check("warm_o5", int'(out_data), 4); check("warm_f5", int'(fill), 4);

        // Full-scale windows must not wrap.
        repeat (4) cycle(1, 127, 0);
        check("max_pos", int'(out_data), 127);
        repeat (4) cycle(1, -128, 0);
        check("max_neg", int'(out_data), -128);

        // Rounding / floor behaviour on small fresh windows.
        do_reset();
        cycle(1, 1, 0);
        repeat (3) cycle(1, 0, 0);
        check("one_then_zero", int'(out_data), 0);
        do_reset();
        cycle(1, 2, 0);
`ifdef MOVING_AVERAGE_N_ROUND_EN
        check("two_round", int'(out_data), 1);
`else
        check("two_floor", int'(out_data), 0);
`endif
        do_reset();
        cycle(1, -1, 0);
`ifdef MOVING_AVERAGE_N_ROUND_EN
        check("neg1_round", int'(out_data), 0);
`else
        check("neg1_floor", int'(out_data), -1);
`endif

        // Gaps leave state untouched and output held.
        do_reset();
        cycle(1, 8, 0); check("gap_o1", int'(out_data), 2);
        repeat (3) begin
            cycle(0, 99, 0);
            check("gap_valid", int'(out_valid), 0);
            check("gap_hold", int'(out_data), 2);
        end
        cycle(1, 8, 0); check("gap_o2", int'(out_data), 4); check("gap_fill", int'(fill), 2);

        // Clear wins over a simultaneous sample.
        do_reset();
        repeat (4) cycle(1, 8, 0);
        check("clr_primed_out", int'(out_data), 8);
        cycle(1, 8, 1);
        check("clr_valid", int'(out_valid), 0);
        check("clr_fill", int'(fill), 0);
        check("clr_hold", int'(out_data), 8);
        cycle(1, 8, 0); check("clr_next", int'(out_data), 2);

        // Asynchronous reset mid-stream, between clock edges.
        cycle(1, 4, 0);
        cycle(1, 4, 0);
        #2;
        system1000_rst = 1'b1;
        model_reset();
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_fill", int'(fill), 0);
        check("arst_primed", int'(primed), 0);
        @(posedge system1000);
        #1;
        system1000_rst = 1'b0;
        cycle(1, 4, 0); check("arst_after", int'(out_data), 1);
        cycle(0, 0, 0);

        @(negedge system1000);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
